// File: rtl/dytr3_pkg.sv
// Shared definitions for the dytr3 redundancy controller: FSM encoding and
// phase-window constants.
package dytr3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_REC1 = 3'd2,
        ST_REC2 = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    localparam logic [1:0] PH_LAST = 2'd2;
    localparam int         REC_LEN = 2;

    // True for both recovery states; used to drive fetchA/recov together.
    function automatic logic is_rec(input state_t st);
        return (st == ST_REC1) || (st == ST_REC2);
    endfunction

endpackage

// File: rtl/dytr3_phase_cnt.sv
// Mod-3 redundancy phase counter (0,1,2,0,...) with hold and clear controls.
module dytr3_phase_cnt
    import dytr3_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold,
    input  logic       clear,
    output logic [1:0] phase
);

    logic [1:0] phase_r;

    // Phase register: clear beats hold, otherwise wrap after PH_LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= 2'd0;
        end else if (clear) begin
            phase_r <= 2'd0;
        end else if (hold) begin
            phase_r <= phase_r;
        end else if (phase_r == PH_LAST) begin
            phase_r <= 2'd0;
        end else begin
            phase_r <= phase_r + 2'd1;
        end
    end

    assign phase = phase_r;

endmodule

// File: rtl/dytr3_ctrl.sv
// Redundancy controller: sequences save/fetch phases for protected flip-flop
// blocks, counts detected mismatches and halts on a persistent fault.
module dytr3_ctrl
    import dytr3_pkg::*;
#(
    parameter int NFF    = 8,
    parameter int CNTW   = 8,
    parameter int MAXREC = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NFF-1:0]  fail,
    input  logic            clr,
    output logic            modeS,
    output logic            fetchA,
    output logic [1:0]      phase,
    output logic            recov,
    output logic [CNTW-1:0] err_cnt,
    output logic            alarm
);

    localparam int CW = $clog2(MAXREC + 1);

    state_t          state_r;
    state_t          state_s;
    logic            armed_r;
    logic [CW-1:0]   cons_r;
    logic [CW-1:0]   cons_s;
    logic [CNTW-1:0] err_cnt_r;
    logic            alarm_r;
    logic            modes_r;
    logic            fetcha_r;
    logic            recov_r;
    logic            fail_any_s;
    logic            ph_hold_s;
    logic            ph_clear_s;
    logic            err_inc_s;
    logic            alarm_set_s;
    logic            modes_s;
    logic [1:0]      phase_s;

    assign fail_any_s = |fail;

    dytr3_phase_cnt u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (ph_hold_s),
        .clear (ph_clear_s),
        .phase (phase_s)
    );

    // Next-state, phase control and error/recovery bookkeeping.
    always_comb begin
        state_s     = state_r;
        cons_s      = cons_r;
        ph_hold_s   = 1'b0;
        ph_clear_s  = 1'b0;
        err_inc_s   = 1'b0;
        alarm_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ph_clear_s = 1'b1;
                if (armed_r && en) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A detection beats the en-driven exit at the end of a window.
                if (fail_any_s) begin
                    state_s   = ST_REC1;
                    ph_hold_s = 1'b1;
                    err_inc_s = 1'b1;
                end else if (phase_s == PH_LAST) begin
                    cons_s = {CW{1'b0}};
                    if (!en) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_REC1: begin
                state_s   = ST_REC2;
                ph_hold_s = 1'b1;
            end
            ST_REC2: begin
                ph_clear_s = 1'b1;
                cons_s     = cons_r + CW'(1);
                if (cons_r == CW'(MAXREC - 1)) begin
                    state_s     = ST_HALT;
                    alarm_set_s = 1'b1;
                end else if (en) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HALT: begin
                ph_clear_s = 1'b1;
                if (clr) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                ph_clear_s = 1'b1;
            end
        endcase
    end

    // modeS leads phase by one edge: high when the next RUN phase is PH_LAST.
    always_comb begin
        if ((state_r == ST_RUN) && (phase_s == 2'd1) && !fail_any_s) begin
            modes_s = 1'b1;
        end else begin
            modes_s = 1'b0;
        end
    end

    // FSM state and the reset-release arming flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            armed_r <= 1'b0;
        end else begin
            state_r <= state_s;
            armed_r <= 1'b1;
        end
    end

    // Error counter, consecutive-recovery counter and alarm; clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= {CNTW{1'b0}};
            cons_r    <= {CW{1'b0}};
            alarm_r   <= 1'b0;
        end else if (clr) begin
            err_cnt_r <= {CNTW{1'b0}};
            cons_r    <= {CW{1'b0}};
            alarm_r   <= 1'b0;
        end else begin
            if (err_inc_s && (err_cnt_r != {CNTW{1'b1}})) begin
                err_cnt_r <= err_cnt_r + CNTW'(1);
            end else begin
                err_cnt_r <= err_cnt_r;
            end
            cons_r  <= cons_s;
            alarm_r <= alarm_r | alarm_set_s;
        end
    end

    // Registered broadcast strobes decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modes_r  <= 1'b0;
            fetcha_r <= 1'b0;
            recov_r  <= 1'b0;
        end else begin
            modes_r  <= modes_s;
            fetcha_r <= is_rec(state_s);
            recov_r  <= is_rec(state_s);
        end
    end

    assign modeS   = modes_r;
    assign fetchA  = fetcha_r;
    assign recov   = recov_r;
    assign phase   = phase_s;
    assign err_cnt = err_cnt_r;
    assign alarm   = alarm_r;

endmodule

// File: tb/tb_dytr3_ctrl.sv
// Scoreboard bench for dytr3_ctrl: directed scenarios plus random traffic,
// checked against a rule-level reference model (second instance with CNTW=2).
module tb_dytr3_ctrl;

    localparam int M_IDLE = 0, M_RUN = 1, M_REC1 = 2, M_REC2 = 3, M_HALT = 4;
    localparam int MAXREC = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] fail = 8'h00;
    logic       clr = 1'b0;
    logic       modeS, fetchA, recov, alarm;
    logic [1:0] phase;
    logic [7:0] err_cnt;
    logic       modeS2, fetchA2, recov2, alarm2;
    logic [1:0] phase2;
    logic [1:0] err_cnt2;

    always #5 clk = ~clk;

    dytr3_ctrl #(.NFF(8), .CNTW(8), .MAXREC(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .fail(fail), .clr(clr),
        .modeS(modeS), .fetchA(fetchA), .phase(phase), .recov(recov),
        .err_cnt(err_cnt), .alarm(alarm)
    );

    dytr3_ctrl #(.NFF(8), .CNTW(2), .MAXREC(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .fail(fail), .clr(clr),
        .modeS(modeS2), .fetchA(fetchA2), .phase(phase2), .recov(recov2),
        .err_cnt(err_cnt2), .alarm(alarm2)
    );

    typedef struct {
        int ph; int ms; int fa; int rc; int ec; int ec2; int al;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic rst_val = 1'b0;

    // Reference model state (values visible after the most recent edge).
    int m_st = M_IDLE, m_ph = 0, m_ec = 0, m_ec2 = 0, m_cons = 0, m_al = 0, m_armed = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One rising edge of the behavioural rules.
    task automatic model_step(input logic e, input logic anyf, input logic c);
        int nst, nph, nec, nec2, ncons, nal;
        if (!rst_val) begin
            m_st = M_IDLE; m_ph = 0; m_ec = 0; m_ec2 = 0;
            m_cons = 0; m_al = 0; m_armed = 0;
            return;
        end
        nst = m_st; nph = m_ph; nec = m_ec; nec2 = m_ec2; ncons = m_cons; nal = m_al;
        if (m_st == M_IDLE) begin
            nph = 0;
            if (m_armed != 0 && e) nst = M_RUN;
        end else if (m_st == M_RUN) begin
            if (anyf) begin
                nst = M_REC1;
                nec = (m_ec < 255) ? m_ec + 1 : 255;
                nec2 = (m_ec2 < 3) ? m_ec2 + 1 : 3;
            end else if (m_ph == 2) begin
                ncons = 0; nph = 0;
                if (!e) nst = M_IDLE;
            end else begin
                nph = m_ph + 1;
            end
        end else if (m_st == M_REC1) begin
            nst = M_REC2;
        end else if (m_st == M_REC2) begin
            nph = 0;
            ncons = m_cons + 1;
            if (ncons == MAXREC) begin
                nst = M_HALT; nal = 1;
            end else begin
                nst = e ? M_RUN : M_IDLE;
            end
        end else begin
            if (c) nst = M_IDLE;
        end
        if (c) begin
            nec = 0; nec2 = 0; ncons = 0; nal = 0;
        end
        m_st = nst; m_ph = nph; m_ec = nec; m_ec2 = nec2; m_cons = ncons; m_al = nal;
        m_armed = 1;
    endtask

    task automatic cyc(input logic e, input logic [7:0] f, input logic c);
        exp_t x;
        @(negedge clk);
        rst_n = rst_val; en = e; fail = f; clr = c;
        model_step(e, f != 8'h00, c);
        x.ph = m_ph;
        x.ms = (m_st == M_RUN && m_ph == 2) ? 1 : 0;
        x.fa = (m_st == M_REC1 || m_st == M_REC2) ? 1 : 0;
        x.rc = x.fa;
        x.ec = m_ec; x.ec2 = m_ec2; x.al = m_al;
        q.push_back(x);
    endtask

    // Assert reset between edges and check that outputs drop at once.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_val = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_phase", int'(phase), 0);
        chk("rst_modeS", int'(modeS), 0);
        chk("rst_fetchA", int'(fetchA), 0);
        chk("rst_recov", int'(recov), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_alarm", int'(alarm), 0);
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b1, 8'h00, 1'b0);
        rst_val = 1'b1;
    endtask

    task automatic run_until_ph(input int p);
        for (int i = 0; i < 20 && !(m_st == M_RUN && m_ph == p); i++) cyc(1'b1, 8'h00, 1'b0);
        chk("reach_run_phase", (m_st == M_RUN && m_ph == p) ? 1 : 0, 1);
    endtask

    // Monitor: compare every output after each rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("phase", int'(phase), x.ph);
                chk("modeS", int'(modeS), x.ms);
                chk("fetchA", int'(fetchA), x.fa);
                chk("recov", int'(recov), x.rc);
                chk("err_cnt", int'(err_cnt), x.ec);
                chk("err_cnt_w2", int'(err_cnt2), x.ec2);
                chk("alarm", int'(alarm), x.al);
                chk("alarm_w2", int'(alarm2), x.al);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Power-on reset, then clean running.
        #1;
        chk("por_fetchA", int'(fetchA), 0);
        chk("por_err_cnt", int'(err_cnt), 0);
        cyc(1'b1, 8'h00, 1'b0);
        rst_val = 1'b1;
        repeat (12) cyc(1'b1, 8'h00, 1'b0);

        // Single error at phase 1.
        run_until_ph(1);
        cyc(1'b1, 8'h04, 1'b0);
        repeat (8) cyc(1'b1, 8'h00, 1'b0);

        // Persistent fault to HALT, then clr coinciding with a held fail.
        cyc(1'b1, 8'h00, 1'b1);
        repeat (12) cyc(1'b1, 8'h01, 1'b0);
        chk("halted", (m_st == M_HALT) ? 1 : 0, 1);
        cyc(1'b1, 8'h01, 1'b1);
        repeat (6) cyc(1'b1, 8'h00, 1'b0);

        // en drop mid-window, en drop during recovery, fail at exit edge.
        run_until_ph(0);
        repeat (5) cyc(1'b0, 8'h00, 1'b0);
        repeat (3) cyc(1'b1, 8'h00, 1'b0);
        run_until_ph(1);
        cyc(1'b1, 8'h02, 1'b0);
        repeat (4) cyc(1'b0, 8'h00, 1'b0);
        repeat (2) cyc(1'b1, 8'h00, 1'b0);
        run_until_ph(2);
        cyc(1'b0, 8'h20, 1'b0);
        repeat (4) cyc(1'b1, 8'h00, 1'b0);

        // Five isolated errors: narrow counter saturates, no alarm.
        cyc(1'b1, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) begin
            run_until_ph(0);
            cyc(1'b1, 8'h80, 1'b0);
            repeat (6) cyc(1'b1, 8'h00, 1'b0);
        end

        // Reset while in REC1.
        run_until_ph(0);
        cyc(1'b1, 8'h10, 1'b0);
        async_reset();
        repeat (4) cyc(1'b1, 8'h00, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic       e, c;
            logic [7:0] f;
            e = ($urandom % 8) != 0;
            f = (($urandom % 5) == 0) ? 8'($urandom) : 8'h00;
            c = ($urandom % 30) == 0;
            cyc(e, f, c);
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dytr3_ctrl.md
DYTR3_CTRL -- requirements
Module: dytr3_ctrl

Interface
REQ-001 Parameter NFF, default 8: number of protected flip-flop blocks whose fail flags are monitored.
REQ-002 Parameter CNTW, default 8: error-counter width.
REQ-003 Parameter MAXREC, default 3: consecutive recoveries that raise the alarm.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  redundant operation enable.
REQ-007 fail  in  NFF  per-block mismatch flags from the protected flip-flop blocks.
REQ-008 clr  in  1  synchronous clear of counter, alarm and halt.
REQ-009 modeS  out  1  state-save strobe, broadcast to all protected blocks.
REQ-010 fetchA  out  1  recovery (fetch) select, broadcast to all protected blocks.
REQ-011 phase  out  2  current redundancy phase, 0..2.
REQ-012 recov  out  1  high while recovering.
REQ-013 err_cnt  out  CNTW  saturating count of detected errors.
REQ-014 alarm  out  1  sticky persistent-fault flag.

Function
REQ-015 FSM states: IDLE, RUN, REC1, REC2, HALT; all outputs are registered.
REQ-016 IDLE outputs: modeS=0, fetchA=0, phase=0, recov=0.
REQ-017 IDLE with en=1 -> RUN with phase=0.
REQ-018 RUN phase sequence: 0,1,2,0,...; advances one step per cycle.
REQ-019 RUN outputs: modeS=1 exactly in cycles with phase=2, else 0; fetchA=0.
REQ-020 Error detection: any fail bit high in a RUN cycle -> next cycle REC1.
REQ-021 Error count: same edge as REQ-020, err_cnt increments, saturating at all-ones.
REQ-022 Error phase: same edge as REQ-020, phase is held.
REQ-023 REC1 and REC2 outputs: fetchA=1, recov=1, modeS=0.
REQ-024 Recovery sequence: REC1 -> REC2 -> RUN with phase=0; 2-cycle recovery.
REQ-025 fail during REC1/REC2 is ignored and not counted.
REQ-026 Consecutive-recovery counter: increments on each REC2 exit.
REQ-027 Consecutive-recovery counter clears on completion of a full clean phase 0,1,2 window in RUN.
REQ-028 Alarm: on the recovery that brings the consecutive count to MAXREC, REC2 -> HALT instead of RUN, and alarm=1.
REQ-029 HALT outputs: modeS=0, fetchA=0, recov=0, phase=0; remains in HALT until clr or reset.
REQ-030 clr=1: err_cnt=0, alarm=0, consecutive count=0; HALT -> IDLE.
REQ-031 clr=1 in other states: state is unaffected.
REQ-032 clr has priority over a simultaneous err_cnt increment.
REQ-033 en=0 in RUN: completes the current phase window, then leaves to IDLE after the phase=2 cycle.
REQ-034 en=0 in REC1/REC2: completes recovery, then goes to IDLE rather than RUN.
REQ-035 fail high in the same RUN cycle that en-exit would occur: recovery takes priority over the exit.

Reset
REQ-036 rst_n low: state=IDLE, phase=0, modeS=0, fetchA=0, recov=0, err_cnt=0, alarm=0, consecutive count=0, immediately and asynchronously.
REQ-037 Reset asserted mid-recovery or in HALT: same result as REQ-036.
REQ-038 Reset release: first RUN cycle no earlier than the second rising edge with en=1.

Structure
REQ-039 Shared package holds the FSM state encoding and the phase constants PH_LAST=2 and REC_LEN=2.
REQ-040 One sub-module, dytr3_phase_cnt, implements the mod-3 phase counter with hold and clear inputs.
REQ-041 The fail OR-reduction stays inline.

Verification
REQ-042 Reset, en=1 held, fail=0 for 9 cycles -> phase 0,1,2 x3; modeS high on cycles 3,6,9 of RUN; err_cnt=0.
REQ-043 Single error: fail=8'h04 for one cycle at phase=1 -> fetchA=1 for exactly 2 cycles; RUN resumes at phase=0; err_cnt=1; alarm=0.
REQ-044 Persistent fault: fail=8'h01 held constantly -> three recoveries, then HALT, alarm=1, err_cnt=3, modeS=fetchA=0.
REQ-045 Clear with increment: clr pulsed in HALT, coinciding with a detection edge -> err_cnt=0, alarm=0, IDLE, then RUN.
REQ-046 Saturation: CNTW=2, five isolated errors separated by clean windows -> err_cnt sticks at 3; alarm=0.
REQ-047 Reset during REC1 -> all outputs zero immediately; IDLE after release.
